// File: rtl/dtlb_responder.sv
// Fully associative data TLB with single outstanding page-table walk,
// passthrough for bare/M-mode, {U,W,R} permission checking and a
// one-entry walk-fault register that reports a fault on the retried access.
module dtlb_responder #(
    parameter int NUM_ENTRIES = 8,
    parameter int VPN_W       = 27,
    parameter int PPN_W       = 28
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             vm_enable_i,
    input  logic [1:0]       priv_lvl_i,
    input  logic             req_valid_i,
    input  logic [VPN_W-1:0] req_vpn_i,
    input  logic             req_store_i,
    output logic             tlb_ready_o,
    output logic             resp_miss_o,
    output logic [PPN_W-1:0] resp_ppn_o,
    output logic             resp_xcpt_load_o,
    output logic             resp_xcpt_store_o,
    output logic             ptw_req_valid_o,
    input  logic             ptw_req_ready_i,
    output logic [VPN_W-1:0] ptw_req_vpn_o,
    input  logic             ptw_resp_valid_i,
    input  logic [PPN_W-1:0] ptw_resp_ppn_i,
    input  logic [2:0]       ptw_resp_perm_i,
    input  logic             ptw_resp_fault_i
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PTW_REQ  = 2'd1;
    localparam logic [1:0] PTW_WAIT = 2'd2;
    localparam logic [1:0] DRAIN    = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [NUM_ENTRIES-1:0] valid_q;
    logic [VPN_W-1:0]       vpn_q  [NUM_ENTRIES];
    logic [PPN_W-1:0]       ppn_q  [NUM_ENTRIES];
    logic [2:0]             perm_q [NUM_ENTRIES];   // {U,W,R}
    logic [IDX_W-1:0]       victim_q;
    logic                   fault_valid_q;
    logic [VPN_W-1:0]       fault_vpn_q;
    logic [VPN_W-1:0]       pend_vpn_q;

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] refill_idx;
    logic [2:0]       hit_perm;
    logic             lookup, passthrough, fault_hit, tlb_hit, miss, perm_fault;
    logic             refill_en, fault_set;

    // CAM match on the request vpn and lowest-index free slot search
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (valid_q[i] && vpn_q[i] == req_vpn_i) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign refill_idx  = free_found ? free_idx : victim_q;
    assign hit_perm    = perm_q[hit_idx];
    assign lookup      = (state_q == IDLE) && req_valid_i;
    assign passthrough = !vm_enable_i || (priv_lvl_i == 2'b11);
    // A pending walk fault outranks both the TLB hit and the miss path
    assign fault_hit   = lookup && !passthrough && fault_valid_q && (fault_vpn_q == req_vpn_i);
    assign tlb_hit     = lookup && !passthrough && !fault_hit && hit;
    assign miss        = lookup && !passthrough && !fault_hit && !hit;
    assign perm_fault  = ( req_store_i && !hit_perm[1]) ||
                         (!req_store_i && !hit_perm[0]) ||
                         (priv_lvl_i == 2'b01 &&  hit_perm[2]) ||
                         (priv_lvl_i == 2'b00 && !hit_perm[2]);

    assign tlb_ready_o       = (state_q == IDLE);
    assign resp_miss_o       = miss;
    assign resp_xcpt_store_o = (fault_hit || (tlb_hit && perm_fault)) &&  req_store_i;
    assign resp_xcpt_load_o  = (fault_hit || (tlb_hit && perm_fault)) && !req_store_i;
    assign ptw_req_valid_o   = (state_q == PTW_REQ);
    assign ptw_req_vpn_o     = pend_vpn_q;

    // Response page number: identity in passthrough, entry ppn on a hit, else zero
    always_comb begin
        resp_ppn_o = '0;
        if (lookup && passthrough) begin
            resp_ppn_o = PPN_W'(req_vpn_i);
        end else if (tlb_hit) begin
            resp_ppn_o = ppn_q[hit_idx];
        end
    end

    // Walk sequencing; flush aborts a walk, draining one response if already issued
    always_comb begin
        state_d   = state_q;
        refill_en = 1'b0;
        fault_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss) state_d = PTW_REQ;
            end
            PTW_REQ: begin
                if (ptw_req_ready_i) state_d = flush_i ? DRAIN : PTW_WAIT;
                else if (flush_i)    state_d = IDLE;
            end
            PTW_WAIT: begin
                if (ptw_resp_valid_i) begin
                    state_d = IDLE;
                    if (!flush_i) begin
                        fault_set = ptw_resp_fault_i;
                        refill_en = !ptw_resp_fault_i;
                    end
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ptw_resp_valid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, entry array, victim pointer, fault and pending registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            victim_q      <= '0;
            fault_valid_q <= 1'b0;
            fault_vpn_q   <= '0;
            pend_vpn_q    <= '0;
        end else begin
            state_q <= state_d;
            if (miss) pend_vpn_q <= req_vpn_i;

            if (flush_i) begin
                valid_q <= '0;
            end else if (refill_en) begin
                valid_q[refill_idx] <= 1'b1;
                vpn_q[refill_idx]   <= pend_vpn_q;
                ppn_q[refill_idx]   <= ptw_resp_ppn_i;
                perm_q[refill_idx]  <= ptw_resp_perm_i;
                victim_q            <= victim_q + IDX_W'(1);
            end

            if (flush_i) begin
                fault_valid_q <= 1'b0;
            end else if (fault_set) begin
                fault_valid_q <= 1'b1;
                fault_vpn_q   <= pend_vpn_q;
            end else if (fault_hit) begin
                fault_valid_q <= 1'b0;
            end
        end
    end

endmodule
